// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the cache-to-RAM port arbiter: word type, RAM handshake
// state, and the arbiter's grant state.
package ram_port_arbiter_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_GNT = 2'd1,
    D_GNT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Cache-side request/response signals plus the single RAM channel.
// The arbiter uses the slave modport; the environment (caches + RAM) the master.
interface ram_port_arbiter_if
  import ram_port_arbiter_pkg::*;
#(
  parameter int WORD_W = ram_port_arbiter_pkg::WORD_W
);
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              iwait;
  logic              dwait;
  logic [WORD_W-1:0] iload;
  logic [WORD_W-1:0] dload;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramload;
  ramstate_t         ramstate;
  logic              fault;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN, fault
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN, fault
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Dcache-first arbiter for one RAM channel with bounded icache starvation
// and a bounded ERROR-retry budget per transfer.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int D_STREAK_MAX = 4,
  parameter int RETRY_MAX    = 3
)(
  input logic               CLK,
  input logic               RST,
  ram_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(D_STREAK_MAX + 1);
  localparam int RW = $clog2(RETRY_MAX + 1);
  localparam logic [SW-1:0] STREAK_LIM = SW'(D_STREAK_MAX);
  localparam logic [RW-1:0] RETRY_LIM  = RW'(RETRY_MAX);

  arb_state_t    state;
  logic [SW-1:0] streak;
  logic [RW-1:0] retries;
  logic          fault_q;

  logic d_req, force_i, live, access, give_up, done, pulse;

  assign d_req   = bus.dREN | bus.dWEN;
  assign force_i = bus.iREN && (streak == STREAK_LIM);
  // A grant is only live while its owner still asserts the request.
  assign live    = (state == I_GNT) ? bus.iREN :
                   (state == D_GNT) ? d_req    : 1'b0;
  assign access  = live && (bus.ramstate == ACCESS);
  assign give_up = live && (bus.ramstate == ERROR) && (retries == RETRY_LIM);
  assign done    = access | give_up;
  // Reset aborts the transfer silently: no wait pulse in the reset cycle.
  assign pulse   = done & ~RST;
  assign bus.fault = fault_q;

  always_comb begin
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    case (state)
      I_GNT: begin
        bus.ramaddr = bus.iaddr;
        bus.ramREN  = bus.iREN;
        bus.iload   = bus.ramload;
        bus.iwait   = ~pulse;
      end
      D_GNT: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        // Write wins if both are raised.
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.dload    = bus.ramload;
        bus.dwait    = ~pulse;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      streak  <= '0;
      retries <= '0;
      fault_q <= 1'b0;
    end else begin
      if (!bus.iREN) streak <= '0;
      case (state)
        IDLE: begin
          if (d_req && !force_i) begin
            state <= D_GNT;
            if (bus.iREN && streak != STREAK_LIM) streak <= streak + SW'(1);
          end else if (bus.iREN) begin
            state  <= I_GNT;
            streak <= '0;
          end
        end
        I_GNT, D_GNT: begin
          if (!live || done) begin
            state   <= IDLE;
            retries <= '0;
            if (give_up) fault_q <= 1'b1;
          end else if (bus.ramstate == ERROR) begin
            retries <= retries + RW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
